special_cases_resolver_pipe: RTL

Multi-lane, pipelined successor to the combinational special-case detector for the HUB floating-point multiplier.
- Per lane: classifies operands X and Y as none, ±inf, ±zero or ±one.
- Resolves the product's special result and flags invalid operations (inf×0).
- Sits between operand registers and the mantissa multiplier datapath, behind a valid/ready handshake.
- The multiplier bypasses its datapath for a lane when special_hit is set.

---
 rtl/fphub_special_pkg.sv | 31 +++
 rtl/special_cases_resolver_pipe_if.sv | 30 +++
 rtl/special_case_lane_resolve.sv | 30 +++
 rtl/special_cases_resolver_pipe.sv | 84 ++++++++
 4 files changed

// File: rtl/fphub_special_pkg.sv
// fphub_special_pkg: special-case class codes and width-generic operand classifier for the HUB multiplier
package fphub_special_pkg;
  localparam int MAXW = 128;
  typedef enum logic [2:0] {
    CASE_NONE   = 3'd0,
    CASE_INF_P  = 3'd1,
    CASE_INF_N  = 3'd2,
    CASE_ZERO_P = 3'd3,
    CASE_ZERO_N = 3'd4,
    CASE_ONE_P  = 3'd5,
    CASE_ONE_N  = 3'd6
  } special_case_e;
  function automatic special_case_e classify(input logic [MAXW-1:0] op, input int unsigned w, input bit one_detect);
    logic [MAXW-1:0] body_m;
    logic [MAXW-1:0] low_m;
    logic sign;
    logic msb;
    logic inf;
    logic low0;
    body_m = (MAXW'(1) << (w - 1)) - MAXW'(1);
    low_m  = body_m >> 1;
    sign   = |(op & (MAXW'(1) << (w - 1)));
    msb    = |(op & (MAXW'(1) << (w - 2)));
    inf    = (op & body_m) == body_m;
    low0   = (op & low_m) == '0;
    return inf ? (sign ? CASE_INF_N : CASE_INF_P) :
           !low0 ? CASE_NONE :
           msb ? (one_detect ? (sign ? CASE_ONE_N : CASE_ONE_P) : CASE_NONE) :
           (sign ? CASE_ZERO_N : CASE_ZERO_P);
  endfunction
endpackage

// File: rtl/special_cases_resolver_pipe_if.sv
// special_cases_resolver_pipe_if: in/out valid-ready handshake, packed lane operands, per-lane results and hit counter; slave = resolver, master = producer/consumer
interface special_cases_resolver_pipe_if #(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  localparam int W = E + M + 1;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   X;
  logic [LANES*W-1:0]   Y;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*3-1:0]   X_class;
  logic [LANES*3-1:0]   Y_class;
  logic [LANES-1:0]     special_hit;
  logic [LANES*W-1:0]   special_result;
  logic [LANES-1:0]     invalid;
  logic [CNT_W-1:0]     hit_count;
  logic                 clr_count;
  modport slave (
    input  in_valid, X, Y, out_ready, clr_count,
    output in_ready, out_valid, X_class, Y_class, special_hit, special_result, invalid, hit_count
  );
  modport master (
    output in_valid, X, Y, out_ready, clr_count,
    input  in_ready, out_valid, X_class, Y_class, special_hit, special_result, invalid, hit_count
  );
endinterface

// File: rtl/special_case_lane_resolve.sv
// special_case_lane_resolve: one lane, class codes xc_i/yc_i + operands x_i/y_i -> result_o, hit_o, invalid_o (priority invalid > inf > zero > one)
module special_case_lane_resolve
  import fphub_special_pkg::*;
#(
  parameter int W = 32
) (
  input  special_case_e xc_i,
  input  special_case_e yc_i,
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  y_i,
  output logic [W-1:0]  result_o,
  output logic          hit_o,
  output logic          invalid_o
);
  logic x_inf, y_inf, x_zero, y_zero, x_one, y_one, s;
  assign x_inf  = xc_i inside {CASE_INF_P, CASE_INF_N};
  assign y_inf  = yc_i inside {CASE_INF_P, CASE_INF_N};
  assign x_zero = xc_i inside {CASE_ZERO_P, CASE_ZERO_N};
  assign y_zero = yc_i inside {CASE_ZERO_P, CASE_ZERO_N};
  assign x_one  = xc_i inside {CASE_ONE_P, CASE_ONE_N};
  assign y_one  = yc_i inside {CASE_ONE_P, CASE_ONE_N};
  assign s      = x_i[W-1] ^ y_i[W-1];
  assign invalid_o = (x_inf & y_zero) | (y_inf & x_zero);
  assign hit_o     = x_inf | y_inf | x_zero | y_zero | x_one | y_one;
  assign result_o  = invalid_o       ? {1'b0, {(W-1){1'b1}}} :
                     (x_inf | y_inf)   ? {s, {(W-1){1'b1}}} :
                     (x_zero | y_zero) ? {s, {(W-1){1'b0}}} :
                     x_one             ? {s, y_i[W-2:0]} :
                     y_one             ? {s, x_i[W-2:0]} : '0;
endmodule

// File: rtl/special_cases_resolver_pipe.sv
// special_cases_resolver_pipe: 2-stage elastic multi-lane special-case resolver; clk/rst plain, handshake/operands/results/hit counter on io (slave)
module special_cases_resolver_pipe
  import fphub_special_pkg::*;
#(
  parameter int M          = 23,
  parameter int E          = 8,
  parameter int LANES      = 4,
  parameter int ONE_DETECT = 1,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  special_cases_resolver_pipe_if.slave io
);
  localparam int W = E + M + 1;
  logic                 s1_valid_q, s2_valid_q;
  logic [LANES*3-1:0]   s1_xc_q, s1_yc_q, s2_xc_q, s2_yc_q, xc_d, yc_d;
  logic [LANES*W-1:0]   s1_x_q, s1_y_q, s2_res_q, res_d;
  logic [LANES-1:0]     s2_hit_q, s2_inv_q, hit_d, inv_d;
  logic [CNT_W-1:0]     hit_count_q, cnt_d;
  logic [CNT_W:0]       sum;
  logic                 s1_advance, in_fire, s1_fire, out_fire;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign xc_d[i*3 +: 3] = classify(MAXW'(io.X[i*W +: W]), W, ONE_DETECT != 0);
    assign yc_d[i*3 +: 3] = classify(MAXW'(io.Y[i*W +: W]), W, ONE_DETECT != 0);
    special_case_lane_resolve #(.W(W)) u_res (
      .xc_i     (special_case_e'(s1_xc_q[i*3 +: 3])),
      .yc_i     (special_case_e'(s1_yc_q[i*3 +: 3])),
      .x_i      (s1_x_q[i*W +: W]),
      .y_i      (s1_y_q[i*W +: W]),
      .result_o (res_d[i*W +: W]),
      .hit_o    (hit_d[i]),
      .invalid_o(inv_d[i])
    );
  end
  assign s1_advance = !s2_valid_q | io.out_ready;
  assign io.in_ready = !s1_valid_q | s1_advance;
  assign in_fire  = io.in_valid & io.in_ready;
  assign s1_fire  = s1_valid_q & s1_advance;
  assign out_fire = s2_valid_q & io.out_ready;
  // popcount never exceeds LANES, so one extra bit is enough to detect overflow
  assign sum   = {1'b0, hit_count_q} + (CNT_W+1)'($countones(s2_hit_q));
  assign cnt_d = io.clr_count ? '0 : out_fire ? (sum[CNT_W] ? '1 : sum[CNT_W-1:0]) : hit_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_xc_q     <= '0;
      s1_yc_q     <= '0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s2_xc_q     <= '0;
      s2_yc_q     <= '0;
      s2_res_q    <= '0;
      s2_hit_q    <= '0;
      s2_inv_q    <= '0;
      hit_count_q <= '0;
    end else begin
      if (io.in_ready) s1_valid_q <= io.in_valid;
      if (in_fire) begin
        s1_xc_q <= xc_d;
        s1_yc_q <= yc_d;
        s1_x_q  <= io.X;
        s1_y_q  <= io.Y;
      end
      if (s1_advance) s2_valid_q <= s1_valid_q;
      if (s1_fire) begin
        s2_xc_q  <= s1_xc_q;
        s2_yc_q  <= s1_yc_q;
        s2_res_q <= res_d;
        s2_hit_q <= hit_d;
        s2_inv_q <= inv_d;
      end
      hit_count_q <= cnt_d;
    end
  end
  assign io.out_valid      = s2_valid_q;
  assign io.X_class        = s2_xc_q;
  assign io.Y_class        = s2_yc_q;
  assign io.special_hit    = s2_hit_q;
  assign io.special_result = s2_res_q;
  assign io.invalid        = s2_inv_q;
  assign io.hit_count      = hit_count_q;
endmodule
